awb_gray_world: RTL
===================

// Module: awb_gray_world
// PURPOSE
//  Gray-world auto white balance stage, directly downstream of the Bayer CFA demosaic.
//  Consumes the RGB888 stream (vs/de/r/g/b) and accumulates per-channel sums over each frame.
//  In vertical blanking, a sequential divider computes R and B gains relative to G.
//  Gains are applied to subsequent frames through a 2-stage multiply/round/clamp pipeline.
// PARAMETERS
//  SUM_W      32  channel accumulator width (fits 1920x1080x255)
//  GAIN_FRAC  8   fractional bits of gains; unity = 2**GAIN_FRAC = 256
//  GAIN_W     10  gain width, unsigned Q2.8 (max 1023 = 3.996x)
// PORTS
//  I_clk        in   1       pixel clock
//  I_rst        in   1       async reset, active-high
//  I_rgb_vs     in   1       frame valid, high for the whole active frame
//  I_rgb_de     in   1       pixel valid
//  I_rgb_r/g/b  in   8 each  demosaiced pixel
//  I_awb_en     in   1       1: apply computed gains; 0: unity gains (bypass, same latency)
//  O_rgb_vs     out  1       I_rgb_vs delayed 2 cycles
//  O_rgb_de     out  1       I_rgb_de delayed 2 cycles
//  O_rgb_r/g/b  out  8 each  balanced pixel; 0 when O_rgb_de=0
//  O_gain_r     out  GAIN_W  R gain currently applied
//  O_gain_b     out  GAIN_W  B gain currently applied
//  O_gain_valid out  1       one-cycle pulse when new gains are committed
// BEHAVIOUR
//  Reset (async, I_rst=1): all outputs 0 except O_gain_r = O_gain_b = 256.
//   Clears accumulators, pending gains and FSM; no pending-gain flag.
//  Accumulate: when I_rgb_vs & I_rgb_de, sum_x += I_rgb_x for x in {r,g,b}.
//   Accumulators clear on the cycle after the vs rising edge.
//  Frame end = vs falling edge (vs_d1=1, vs=0): snapshot sums, FSM IDLE->DIV_R.
//  FSM: IDLE -> DIV_R -> DIV_B -> DONE -> IDLE.
//   DIV_R/DIV_B: restoring divide, 1 bit/cycle, SUM_W+GAIN_FRAC cycles each.
//   DONE (1 cycle): write pending gains, set pending flag.
//   Gain calculation: num = sum_g << GAIN_FRAC; gain = floor(num / sum_c).
//    Clamp to 2**GAIN_W-1. If sum_c == 0, gain = 256.
//  Commit: on the first vs rising edge with the pending flag set,
//   active gains <= pending, flag clears, O_gain_valid pulses that cycle.
//   Gains never change mid-frame.
//  Overlap: the divider works only on snapshots, so a vs rise while DIV_* is busy is legal.
//   The new frame accumulates normally; gains finishing after that rise commit one frame later.
//   A vs falling edge while busy is ignored; the divide finishes with the old snapshot.
//  Datapath, with G gain fixed at 256:
//   Stage 1: prod = pix * gain (8 x GAIN_W).
//   Stage 2: out = min(255, (prod + 128) >> GAIN_FRAC).
//   If I_awb_en=0, the effective gain is 256 (active gains stay unchanged).
//   I_awb_en is sampled per pixel.
//  Latency is exactly 2 cycles for vs/de/data, with no stalls or backpressure.
//  Accumulation and gain computation keep running when I_awb_en=0.
// TESTING
//  T1 reset: I_rst pulse mid-frame -> outputs 0, gains 256, no O_gain_valid on the next vs rise.
//  T2 basic (en=1): 4x4 frame R=64,G=128,B=100; gains 512/327 pulse on frame-2 vs rise.
//   Frame-2 output: R=128, G=128, B=128.
//  T3 saturation: frame R=10,G=200,B=200 -> gain_r clamps to 1023.
//   Next-frame R=200 input -> out 255.
//  T4 zero channel: frame R=0,G=50,B=50 -> gain_r=256, gain_b=256; outputs equal inputs.
//  T5 bypass (en=0) after T2 gains -> O_rgb_* = I_rgb_* delayed 2; O_gain_* still 512/327.
//  T6 short blanking: vs rise 5 cycles after the fall of frame 1.
//   Frame 2 uses the old gains; frame-1 gains commit at the frame-3 vs rise with one pulse.

Source files
------------

// File: rtl/awb_gray_world.sv
// ---------------------------------------------------------------------------
// awb_gray_world
//   Gray-world auto white balance on an RGB888 stream. Per-channel sums are
//   accumulated over each frame; after the frame ends a 1-bit/cycle restoring
//   divider computes R and B gains relative to G (unsigned Q2.8). New gains
//   take effect at the next frame start and are applied through a 2-stage
//   multiply / round / clamp pipeline. G is always passed at unity gain.
//
// Ports
//   I_clk, I_rst                  pixel clock, async active-high reset
//   I_rgb_vs/de/r/g/b             input stream (vs = frame valid, de = pixel valid)
//   I_awb_en                      1: apply gains, 0: unity gains (same latency)
//   O_rgb_vs/de/r/g/b             balanced stream, 2 cycles behind the input;
//                                 pixel data is 0 when O_rgb_de = 0
//   O_gain_r, O_gain_b            gains currently in use (Q2.8)
//   O_gain_valid                  one-cycle pulse when new gains are committed
// ---------------------------------------------------------------------------
module awb_gray_world #(
    parameter int SUM_W     = 32,
    parameter int GAIN_FRAC = 8,
    parameter int GAIN_W    = 10
) (
    input  logic              I_clk,
    input  logic              I_rst,
    input  logic              I_rgb_vs,
    input  logic              I_rgb_de,
    input  logic [7:0]        I_rgb_r,
    input  logic [7:0]        I_rgb_g,
    input  logic [7:0]        I_rgb_b,
    input  logic              I_awb_en,
    output logic              O_rgb_vs,
    output logic              O_rgb_de,
    output logic [7:0]        O_rgb_r,
    output logic [7:0]        O_rgb_g,
    output logic [7:0]        O_rgb_b,
    output logic [GAIN_W-1:0] O_gain_r,
    output logic [GAIN_W-1:0] O_gain_b,
    output logic              O_gain_valid
);

    localparam int NUM_W  = SUM_W + GAIN_FRAC;
    localparam int CNT_W  = $clog2(NUM_W);
    localparam int PROD_W = 8 + GAIN_W;

    localparam logic [GAIN_W-1:0] UNITY    = GAIN_W'(1 << GAIN_FRAC);
    localparam logic [GAIN_W-1:0] GAIN_MAX = '1;

    typedef enum logic [1:0] {IDLE, DIV_R, DIV_B, DONE} state_t;

    state_t state, state_nx;

    logic              vs_d1, vs_rise, vs_fall, commit;
    logic [SUM_W-1:0]  acc_r, acc_g, acc_b;
    logic [SUM_W-1:0]  snap_g, snap_b, den;
    logic [NUM_W-1:0]  quo, quo_nx;
    logic [SUM_W:0]    rem, rem_sh, rem_nx;
    logic              q_bit, div_last;
    logic [CNT_W-1:0]  cnt;
    logic [GAIN_W-1:0] gain_res, calc_r, calc_b;
    logic [GAIN_W-1:0] pend_r, pend_b;
    logic              pend_flag;
    logic [GAIN_W-1:0] gain_eff_r, gain_eff_b;
    logic [PROD_W-1:0] prod_r, prod_g, prod_b;
    logic              vs_s1, de_s1;

    assign vs_rise = I_rgb_vs & ~vs_d1;
    assign vs_fall = ~I_rgb_vs & vs_d1;
    assign commit  = vs_rise & pend_flag;

    // -------------------------------------------------------------------
    // Frame accumulators. A pixel arriving on the vs rising cycle seeds
    // the new frame's sums instead of being added to the old ones.
    // -------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            vs_d1 <= 1'b0;
            acc_r <= '0;
            acc_g <= '0;
            acc_b <= '0;
        end else begin
            vs_d1 <= I_rgb_vs;
            if (vs_rise) begin
                acc_r <= I_rgb_de ? SUM_W'(I_rgb_r) : '0;
                acc_g <= I_rgb_de ? SUM_W'(I_rgb_g) : '0;
                acc_b <= I_rgb_de ? SUM_W'(I_rgb_b) : '0;
            end else if (I_rgb_vs && I_rgb_de) begin
                acc_r <= acc_r + SUM_W'(I_rgb_r);
                acc_g <= acc_g + SUM_W'(I_rgb_g);
                acc_b <= acc_b + SUM_W'(I_rgb_b);
            end
        end
    end

    // -------------------------------------------------------------------
    // Restoring divider step. The dividend shifts out of the top of quo
    // while quotient bits shift in at the bottom, so after NUM_W steps quo
    // holds floor((sum_g << GAIN_FRAC) / den).
    // -------------------------------------------------------------------
    always_comb begin
        rem_sh   = {rem[SUM_W-1:0], quo[NUM_W-1]};
        q_bit    = (rem_sh >= {1'b0, den});
        rem_nx   = q_bit ? (rem_sh - {1'b0, den}) : rem_sh;
        quo_nx   = {quo[NUM_W-2:0], q_bit};
        div_last = (cnt == CNT_W'(NUM_W - 1));
        if (den == '0)
            gain_res = UNITY;
        else if (|quo_nx[NUM_W-1:GAIN_W])
            gain_res = GAIN_MAX;
        else
            gain_res = quo_nx[GAIN_W-1:0];
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) state <= IDLE;
        else       state <= state_nx;
    end

    // NOTE: every signal assigned in always_comb gets a default first so
    // no path leaves it unassigned and infers a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:  if (vs_fall)  state_nx = DIV_R;
            DIV_R: if (div_last) state_nx = DIV_B;
            DIV_B: if (div_last) state_nx = DONE;
            DONE:                state_nx = IDLE;
        endcase
    end

    // A vs fall outside IDLE is ignored; the divide keeps its snapshot.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            quo    <= '0;
            rem    <= '0;
            den    <= '0;
            cnt    <= '0;
            snap_g <= '0;
            snap_b <= '0;
            calc_r <= UNITY;
            calc_b <= UNITY;
        end else begin
            unique case (state)
                IDLE: if (vs_fall) begin
                    quo    <= {acc_g, {GAIN_FRAC{1'b0}}};
                    rem    <= '0;
                    den    <= acc_r;
                    cnt    <= '0;
                    snap_g <= acc_g;
                    snap_b <= acc_b;
                end
                DIV_R: begin
                    if (div_last) begin
                        calc_r <= gain_res;
                        quo    <= {snap_g, {GAIN_FRAC{1'b0}}};
                        rem    <= '0;
                        den    <= snap_b;
                        cnt    <= '0;
                    end else begin
                        quo <= quo_nx;
                        rem <= rem_nx;
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DIV_B: begin
                    quo <= quo_nx;
                    rem <= rem_nx;
                    cnt <= cnt + CNT_W'(1);
                    if (div_last) calc_b <= gain_res;
                end
                DONE: ;
            endcase
        end
    end

    // -------------------------------------------------------------------
    // Pending / active gains. Results land in pending during DONE and only
    // move to the active set on a frame start, so a frame never sees a
    // gain change. DONE wins over a same-cycle commit for the flag.
    // -------------------------------------------------------------------
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            pend_r       <= UNITY;
            pend_b       <= UNITY;
            pend_flag    <= 1'b0;
            O_gain_r     <= UNITY;
            O_gain_b     <= UNITY;
            O_gain_valid <= 1'b0;
        end else begin
            O_gain_valid <= commit;
            if (commit) begin
                O_gain_r <= pend_r;
                O_gain_b <= pend_b;
            end
            if (state == DONE) begin
                pend_r    <= calc_r;
                pend_b    <= calc_b;
                pend_flag <= 1'b1;
            end else if (commit) begin
                pend_flag <= 1'b0;
            end
        end
    end

    // -------------------------------------------------------------------
    // Pixel pipeline. On the commit cycle the pending gains are used
    // directly so a pixel on the first cycle of the frame already gets the
    // new gains.
    // -------------------------------------------------------------------
    always_comb begin
        gain_eff_r = commit ? pend_r : O_gain_r;
        gain_eff_b = commit ? pend_b : O_gain_b;
        if (!I_awb_en) begin
            gain_eff_r = UNITY;
            gain_eff_b = UNITY;
        end
    end

    function automatic logic [7:0] round_clamp(input logic [PROD_W-1:0] prod);
        logic [PROD_W:0] rnd;
        rnd = {1'b0, prod} + (PROD_W+1)'(1 << (GAIN_FRAC - 1));
        rnd = rnd >> GAIN_FRAC;
        return (rnd > (PROD_W+1)'(255)) ? 8'hFF : rnd[7:0];
    endfunction

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            vs_s1    <= 1'b0;
            de_s1    <= 1'b0;
            prod_r   <= '0;
            prod_g   <= '0;
            prod_b   <= '0;
            O_rgb_vs <= 1'b0;
            O_rgb_de <= 1'b0;
            O_rgb_r  <= '0;
            O_rgb_g  <= '0;
            O_rgb_b  <= '0;
        end else begin
            vs_s1    <= I_rgb_vs;
            de_s1    <= I_rgb_de;
            prod_r   <= PROD_W'(I_rgb_r) * PROD_W'(gain_eff_r);
            prod_g   <= PROD_W'(I_rgb_g) << GAIN_FRAC;
            prod_b   <= PROD_W'(I_rgb_b) * PROD_W'(gain_eff_b);
            O_rgb_vs <= vs_s1;
            O_rgb_de <= de_s1;
            O_rgb_r  <= de_s1 ? round_clamp(prod_r) : 8'd0;
            O_rgb_g  <= de_s1 ? round_clamp(prod_g) : 8'd0;
            O_rgb_b  <= de_s1 ? round_clamp(prod_b) : 8'd0;
        end
    end

endmodule
